pwm_generator: RTL and testbench
================================

// Module: pwm_generator
// PURPOSE
//  Consumer of the PWM top/compare configuration stream. Accepts top (period - 1)
//  and compare (duty threshold) words with valid strobes into pending registers.
//  Drives a single PWM output from a free-running period counter.
//  Pending values transfer to active registers only at a period boundary, so
//  duty/period changes are glitch-free. Sits between the sequencer and the LED/pin driver.
// PARAMETERS
//  TOP_W  8  width of i_top and of the period counter
//  CMP_W  9  width of i_compare; must be TOP_W+1 so compare > top encodes 100% duty
// PORTS
//  i_clk            in   1      system clock
//  i_rst_n          in   1      asynchronous active-low reset
//  i_top            in   TOP_W  period-1 value; qualified by i_top_valid
//  i_top_valid      in   1      strobe: capture i_top
//  i_compare        in   CMP_W  duty threshold; qualified by i_compare_valid
//  i_compare_valid  in   1      strobe: capture i_compare
//  o_pwm            out  1      PWM output, registered
//  o_period_start   out  1      1-cycle pulse: counter is at 0 (start of a period)
//  o_update         out  1      1-cycle pulse: active registers were reloaded
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   - counter, active/pending top and compare, and pending flags all cleared
//   - state=IDLE; o_pwm=0, o_period_start=0, o_update=0
//   - reset mid-period aborts immediately; no partial period completes
//  Capture:
//   - each valid writes its pending register and sets its flag; last write wins
//   - top and compare are independent; either may arrive without the other
//  States:
//   - IDLE: counter held at 0, o_pwm=0
//     - when top flag is set: load active top; load active compare if its flag is set
//     - clear flags, pulse o_update, go to RUN with counter=0
//   - RUN: counter += 1 each cycle; when counter==active_top the next value is 0
//  Boundary (RUN, counter==active_top):
//   - per field, load the incoming value if its valid is high this cycle, else the
//     pending value if its flag is set, else keep the current active value
//   - flags cleared; o_update=1 next cycle iff any field loaded
//   - new values govern the period starting at counter 0
//  Output rule:
//   - o_pwm <= (counter < active_cmp); one cycle latency from counter
//   - o_period_start <= (state==RUN && counter==0), same one-cycle latency
//   - high cycles per period = min(cmp, top+1); cmp=0 -> constant 0; cmp>top -> constant 1
//   - comparison is unsigned at CMP_W bits (counter zero-extended)
//  Edge cases:
//   - top=0: period is 1 cycle; every cycle is a boundary
//   - valid on the IDLE->RUN cycle is captured as pending, applied at the first boundary
// CONFIGURATION
//  PWM_CENTER_ALIGNED_EN defined:
//   - counter counts up 0..top, then down top-1..1; period = 2*top cycles
//   - boundary (reload, o_period_start) only at counter 0 while counting up
//   - direction register reset to up; top=0 falls back to edge-aligned 1-cycle period
//  Undefined: edge-aligned sawtooth only; no direction register is synthesized.
// TESTING
//  1. Reset, top=3 + cmp=2 strobed together -> o_update pulse; o_pwm repeats 1,1,0,0;
//     o_period_start once every 4 cycles
//  2. top=3: cmp=0 -> o_pwm constant 0; cmp=4 -> constant 1; cmp=3 -> 1,1,1,0
//  3. RUN top=7 cmp=2: cmp=6 strobed mid-period -> duty unchanged until the next
//     counter-0 period, then 6 high of 8; o_update pulses once
//  4. cmp valid on boundary cycle (5) plus earlier pending (3) -> 5 applied, flag cleared
//  5. Assert i_rst_n low mid-RUN -> o_pwm=0 immediately; IDLE until a new top strobe
//  6. (PWM_CENTER_ALIGNED_EN) top=4 cmp=2 -> counts 0,1,2,3,4,3,2,1;
//     o_pwm 1,1,0,0,0,0,0,1 repeating

Source files
------------

// File: rtl/pwm_generator.sv
// pwm_generator: PWM output with pending top/compare registers reloaded only at a period boundary.
// Define PWM_CENTER_ALIGNED_EN for an up/down (center-aligned) counter instead of a sawtooth.
module pwm_generator #(
  parameter int TOP_W = 8,
  parameter int CMP_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [TOP_W-1:0] i_top,
  input  logic             i_top_valid,
  input  logic [CMP_W-1:0] i_compare,
  input  logic             i_compare_valid,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic             o_update
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [TOP_W-1:0] cnt_q, cnt_d, cnt_nxt, top_q, top_d, ptop_q, ptop_d;
  logic [CMP_W-1:0] cmp_q, cmp_d, pcmp_q, pcmp_d;
  logic ptop_f_q, ptop_f_d, pcmp_f_q, pcmp_f_d;
  logic pwm_q, ps_q, upd_q, upd_d, wrap;
`ifdef PWM_CENTER_ALIGNED_EN
  logic dir_q, dir_d;
  // wrap marks the cycle whose successor is counter 0 on the way up
  always_comb begin
    dir_d = 1'b0;
    wrap = 1'b0;
    cnt_nxt = cnt_q + TOP_W'(1);
    if (dir_q) begin
      wrap = cnt_q == TOP_W'(1);
      cnt_nxt = cnt_q - TOP_W'(1);
      dir_d = !wrap;
    end else if (cnt_q == top_q) begin
      wrap = top_q <= TOP_W'(1);
      cnt_nxt = wrap ? '0 : cnt_q - TOP_W'(1);
      dir_d = !wrap;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) dir_q <= 1'b0;
    else dir_q <= state_q == RUN && dir_d;
`else
  assign wrap = cnt_q == top_q;
  assign cnt_nxt = wrap ? '0 : cnt_q + TOP_W'(1);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    top_d = top_q;
    cmp_d = cmp_q;
    upd_d = 1'b0;
    ptop_d = i_top_valid ? i_top : ptop_q;
    pcmp_d = i_compare_valid ? i_compare : pcmp_q;
    ptop_f_d = ptop_f_q | i_top_valid;
    pcmp_f_d = pcmp_f_q | i_compare_valid;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (ptop_f_q) begin
        top_d = ptop_q;
        cmp_d = pcmp_f_q ? pcmp_q : cmp_q;
        ptop_f_d = i_top_valid;
        pcmp_f_d = i_compare_valid;
        upd_d = 1'b1;
        state_d = RUN;
      end
    end else begin
      cnt_d = cnt_nxt;
      // a strobe arriving on the boundary itself bypasses the pending register
      if (wrap) begin
        top_d = i_top_valid ? i_top : ptop_f_q ? ptop_q : top_q;
        cmp_d = i_compare_valid ? i_compare : pcmp_f_q ? pcmp_q : cmp_q;
        ptop_f_d = 1'b0;
        pcmp_f_d = 1'b0;
        upd_d = i_top_valid | ptop_f_q | i_compare_valid | pcmp_f_q;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      top_q <= '0;
      ptop_q <= '0;
      cmp_q <= '0;
      pcmp_q <= '0;
      ptop_f_q <= 1'b0;
      pcmp_f_q <= 1'b0;
      pwm_q <= 1'b0;
      ps_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ptop_q <= ptop_d;
      cmp_q <= cmp_d;
      pcmp_q <= pcmp_d;
      ptop_f_q <= ptop_f_d;
      pcmp_f_q <= pcmp_f_d;
      pwm_q <= state_q == RUN && CMP_W'(cnt_q) < cmp_q;
      ps_q <= state_q == RUN && cnt_q == '0;
      upd_q <= upd_d;
    end
  assign o_pwm = pwm_q;
  assign o_period_start = ps_q;
  assign o_update = upd_q;
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed checks of pwm_generator output, period-start and update pulses.
module tb_pwm_generator;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] top = '0;
  logic [8:0] cmp = '0;
  logic top_valid = 1'b0, cmp_valid = 1'b0;
  logic o_pwm, o_period_start, o_update;
  int checks = 0, errors = 0;
  pwm_generator #(.TOP_W(8), .CMP_W(9)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_top(top),
    .i_top_valid(top_valid),
    .i_compare(cmp),
    .i_compare_valid(cmp_valid),
    .o_pwm(o_pwm),
    .o_period_start(o_period_start),
    .o_update(o_update)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
    end
  endtask
  // patterns are MSB-first: bit n-1 is the first sampled cycle
  task automatic run(input string tag, input int n, input logic [31:0] pwm, input logic [31:0] ps, input logic [31:0] upd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      top_valid = 1'b0;
      cmp_valid = 1'b0;
      chk({tag, ".pwm"}, i, o_pwm, pwm[n-1-i]);
      chk({tag, ".start"}, i, o_period_start, ps[n-1-i]);
      chk({tag, ".update"}, i, o_update, upd[n-1-i]);
    end
  endtask
  task automatic set_top(input logic [7:0] v);
    top = v;
    top_valid = 1'b1;
  endtask
  task automatic set_cmp(input logic [8:0] v);
    cmp = v;
    cmp_valid = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pwm", 0, o_pwm, 1'b0);
    chk("reset.start", 0, o_period_start, 1'b0);
    chk("reset.update", 0, o_update, 1'b0);
    rst_n = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
    set_top(8'd4);
    set_cmp(9'd2);
    run("center", 18, 18'b00_11000001_11000001, 18'b00_10000000_10000000, 18'b01_00000000_00000000);
`else
    set_top(8'd3);
    set_cmp(9'd2);
    run("t1", 10, 10'b0011001100, 10'b0010001000, 10'b0100000000);
    set_cmp(9'd0);
    run("cmp0", 8, 8'b11000000, 8'b10001000, 8'b00010000);
    set_cmp(9'd4);
    run("cmp4", 8, 8'b00001111, 8'b10001000, 8'b00010000);
    set_cmp(9'd3);
    run("cmp3", 8, 8'b11111110, 8'b10001000, 8'b00010000);
    set_top(8'd7);
    set_cmp(9'd2);
    run("top7", 12, 12'b1110_11000000, 12'b1000_10000000, 12'b0001_00000000);
    run("top7b", 3, 3'b110, 3'b100, 3'b000);
    set_cmp(9'd6);
    run("mid", 13, 13'b00000_11111100, 13'b00000_10000000, 13'b00001_00000000);
    set_cmp(9'd3);
    run("pend", 7, 7'b1111110, 7'b1000000, 7'b0000000);
    set_cmp(9'd5);
    run("bnd", 9, 9'b011111000, 9'b010000000, 9'b100000000);
    run("bnd2", 8, 8'b11111000, 8'b10000000, 8'b00000000);
    run("pre_rst", 2, 2'b11, 2'b10, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.pwm", 0, o_pwm, 1'b0);
    chk("rst_mid.start", 0, o_period_start, 1'b0);
    chk("rst_mid.update", 0, o_update, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_cmp(9'd2);
    run("idle", 4, 4'b0000, 4'b0000, 4'b0000);
    set_top(8'd1);
    run("top1", 6, 6'b001111, 6'b001010, 6'b010000);
    set_top(8'd0);
    set_cmp(9'd1);
    run("top0", 4, 4'b1111, 4'b1011, 4'b0100);
    set_cmp(9'd0);
    run("top0cmp0", 3, 3'b100, 3'b111, 3'b100);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
